// File: rtl/serial_link_pkg.sv
// Shared types and constants for the serial target-link frame controller.
// Optional feature macro: SERIAL_PARITY_EN (adds a trailing even-parity bit).
package serial_link_pkg;

  // Frame assembly FSM states; encoding is visible on the debug state port.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RECV  = 2'd1,
    CHECK = 2'd2
  } state_t;

`ifdef SERIAL_PARITY_EN
  // Eight payload bits followed by one even-parity bit.
  localparam int FRAME_BITS = 9;
`else
  localparam int FRAME_BITS = 8;
`endif

  // Bit counter width; large enough for FRAME_BITS in either build.
  localparam int COUNT_W = 4;

  localparam logic [3:0] SIZE_RST  = 4'hF;
  localparam logic [3:0] COLOR_RST = 4'hF;

endpackage

// File: rtl/serial_sync_edge.sv
// Synchroniser and rising-edge detector for the asynchronous RCLK/RDATA pair.
// Both inputs run through identical chains so the data bit stays aligned with
// the clock edge it belongs to. Edge pulse and bit are registered outputs.
module serial_sync_edge #(
  parameter int SYNC_STAGES = 2
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_rclk,
  input  logic i_rdata,
  output logic o_edge,
  output logic o_bit
);

  logic [SYNC_STAGES-1:0] r_rclk_sync;
  logic [SYNC_STAGES-1:0] r_rdata_sync;
  logic                   r_rclk_prev;
  logic                   r_edge;
  logic                   r_bit;
  logic                   w_rclk_last;
  logic                   w_rdata_last;
  logic                   w_rise;

  assign w_rclk_last  = r_rclk_sync[SYNC_STAGES-1];
  assign w_rdata_last = r_rdata_sync[SYNC_STAGES-1];
  assign w_rise       = w_rclk_last & ~r_rclk_prev;

  // Synchroniser chains keep shifting during reset, and the previous-value
  // register keeps tracking, so an edge already in flight when reset is
  // released is absorbed instead of being reported as data.
  always_ff @(posedge i_clk) begin
    r_rclk_sync  <= {r_rclk_sync[SYNC_STAGES-2:0], i_rclk};
    r_rdata_sync <= {r_rdata_sync[SYNC_STAGES-2:0], i_rdata};
    r_rclk_prev  <= w_rclk_last;
  end

  // Registered edge pulse with the data bit sampled in the same cycle.
  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      r_edge <= 1'b0;
      r_bit  <= 1'b0;
    end else begin
      r_edge <= w_rise;
      r_bit  <= w_rdata_last;
    end
  end

  assign o_edge = r_edge;
  assign o_bit  = r_bit;

endmodule

// File: rtl/serial_frame_ctrl.sv
// Serial target-link frame controller: assembles LSB-first frames from the
// synchronised RCLK/RDATA pair, resynchronises on an idle timeout, and
// publishes SIZE/COLOR to the steering logic.
// Optional feature macro: SERIAL_PARITY_EN (9-bit frames with even parity).
//
// Handshake: NEW_DATA is a level meaning "SIZE/COLOR hold an unconsumed
// frame". The consumer raises ACK for a cycle while NEW_DATA=1; NEW_DATA and
// OVERRUN clear on the following edge. ACK with NEW_DATA=0 is ignored. If a
// commit lands in the same cycle as ACK, the commit wins: the new frame is
// published, NEW_DATA stays 1 and OVERRUN is set.
module serial_frame_ctrl
  import serial_link_pkg::*;
#(
  parameter int IDLE_TIMEOUT = 50000,
  parameter int SYNC_STAGES  = 2
) (
  input  logic       CLK,
  input  logic       RESET,
  input  logic       RCLK,
  input  logic       RDATA,
  input  logic       ACK,
  output logic [3:0] SIZE,
  output logic [3:0] COLOR,
  output logic       NEW_DATA,
  output logic       OVERRUN,
  output logic       FRAME_ERR,
  output logic [7:0] ERR_COUNT,
  output logic [1:0] DBG_STATE
);

  localparam int                IDLE_W   = $clog2(IDLE_TIMEOUT + 1);
  localparam logic [IDLE_W-1:0] IDLE_MAX = IDLE_W'(IDLE_TIMEOUT);

  state_t                  r_state;
  state_t                  w_state_nxt;
  logic [COUNT_W-1:0]      r_count;
  logic [FRAME_BITS-1:0]   r_shift;
  logic [IDLE_W-1:0]       r_idle;
  logic [3:0]              r_size;
  logic [3:0]              r_color;
  logic                    r_new_data;
  logic                    r_overrun;
  logic                    r_frame_err;
  logic [7:0]              r_err_count;

  logic                    w_edge;
  logic                    w_bit;
  logic                    w_store;
  logic                    w_commit;
  logic                    w_frame_err;
  logic                    w_frame_ok;
  logic                    w_timeout;

  serial_sync_edge #(
    .SYNC_STAGES(SYNC_STAGES)
  ) u_sync (
    .i_clk   (CLK),
    .i_reset (RESET),
    .i_rclk  (RCLK),
    .i_rdata (RDATA),
    .o_edge  (w_edge),
    .o_bit   (w_bit)
  );

`ifdef SERIAL_PARITY_EN
  // Even parity: the XOR over payload and parity bit must be zero.
  assign w_frame_ok = ~(^r_shift);
`else
  assign w_frame_ok = 1'b1;
`endif

  assign w_timeout = (r_idle == IDLE_MAX);

  // State register.
  always_ff @(posedge CLK) begin
    if (RESET) r_state <= IDLE;
    else       r_state <= w_state_nxt;
  end

  // Next-state and per-cycle control decode; a stalled frame times out before
  // any coincident edge is considered.
  always_comb begin
    w_state_nxt = r_state;
    w_store     = 1'b0;
    w_commit    = 1'b0;
    w_frame_err = 1'b0;
    case (r_state)
      IDLE: begin
        if (w_edge) begin
          w_store     = 1'b1;
          w_state_nxt = RECV;
        end
      end
      RECV: begin
        if (w_timeout) begin
          w_frame_err = 1'b1;
          w_state_nxt = IDLE;
        end else if (w_edge) begin
          w_store = 1'b1;
          if (r_count == COUNT_W'(FRAME_BITS - 1)) w_state_nxt = CHECK;
        end
      end
      CHECK: begin
        w_state_nxt = IDLE;
        if (w_frame_ok) w_commit    = 1'b1;
        else            w_frame_err = 1'b1;
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  // Frame assembly: bit shift-in, bit count, and mid-frame idle counter.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_shift <= '0;
      r_count <= '0;
      r_idle  <= '0;
    end else begin
      if (w_store) begin
        for (int i = 0; i < FRAME_BITS; i++) begin
          if (r_count == COUNT_W'(i)) r_shift[i] <= w_bit;
        end
        r_count <= r_count + COUNT_W'(1);
      end else if (w_state_nxt == IDLE) begin
        r_count <= '0;
      end
      if (w_edge || (r_state != RECV)) r_idle <= '0;
      else if (!w_timeout)             r_idle <= r_idle + IDLE_W'(1);
    end
  end

  // Published outputs, consumer handshake, and error reporting.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_size      <= SIZE_RST;
      r_color     <= COLOR_RST;
      r_new_data  <= 1'b0;
      r_overrun   <= 1'b0;
      r_frame_err <= 1'b0;
      r_err_count <= 8'h00;
    end else begin
      if (w_commit) begin
        r_size     <= r_shift[7:4];
        r_color    <= r_shift[3:0];
        r_new_data <= 1'b1;
        if (r_new_data) r_overrun <= 1'b1;
      end else if (ACK && r_new_data) begin
        r_new_data <= 1'b0;
        r_overrun  <= 1'b0;
      end
      r_frame_err <= w_frame_err;
      if (w_frame_err && (r_err_count != 8'hFF)) r_err_count <= r_err_count + 8'h01;
    end
  end

  assign SIZE      = r_size;
  assign COLOR     = r_color;
  assign NEW_DATA  = r_new_data;
  assign OVERRUN   = r_overrun;
  assign FRAME_ERR = r_frame_err;
  assign ERR_COUNT = r_err_count;
  assign DBG_STATE = r_state;

endmodule

// File: tb/tb_serial_frame_ctrl.sv
// Bench for serial_frame_ctrl: drives serial frames and checks published
// frames against an expected queue, plus timeout, overrun, reset and
// saturation scenarios. Honours SERIAL_PARITY_EN the same way as the RTL.
module tb_serial_frame_ctrl;

  localparam int IDLE_TO = 40;
  localparam int SS      = 2;
  localparam int HALF    = 4;
  localparam logic [1:0] ST_IDLE  = 2'd0;
  localparam logic [1:0] ST_CHECK = 2'd2;
`ifdef SERIAL_PARITY_EN
  localparam int NBITS = 9;
`else
  localparam int NBITS = 8;
`endif

  logic       CLK;
  logic       RESET;
  logic       RCLK;
  logic       RDATA;
  logic       ACK;
  logic [3:0] SIZE;
  logic [3:0] COLOR;
  logic       NEW_DATA;
  logic       OVERRUN;
  logic       FRAME_ERR;
  logic [7:0] ERR_COUNT;
  logic [1:0] DBG_STATE;

  int checks = 0;
  int errors = 0;
  int exp_err = 0;

  // Bit 8 set means "this frame must be rejected"; else bits [7:0] expected.
  logic [8:0] exp_q[$];
  logic [8:0] mon_exp;
  logic [7:0] mon_prev;

  serial_frame_ctrl #(
    .IDLE_TIMEOUT(IDLE_TO),
    .SYNC_STAGES (SS)
  ) dut (
    .CLK      (CLK),
    .RESET    (RESET),
    .RCLK     (RCLK),
    .RDATA    (RDATA),
    .ACK      (ACK),
    .SIZE     (SIZE),
    .COLOR    (COLOR),
    .NEW_DATA (NEW_DATA),
    .OVERRUN  (OVERRUN),
    .FRAME_ERR(FRAME_ERR),
    .ERR_COUNT(ERR_COUNT),
    .DBG_STATE(DBG_STATE)
  );

  // Clock and reset
  initial CLK = 1'b0;
  always #5 CLK = ~CLK;

  task automatic apply_reset();
    RESET = 1'b1;
    RCLK  = 1'b0;
    RDATA = 1'b0;
    ACK   = 1'b0;
    repeat (5) @(posedge CLK);
    #1;
    RESET   = 1'b0;
    exp_err = 0;
  endtask

  // Driver tasks
  task automatic send_bit(input logic b);
    RCLK  = 1'b0;
    RDATA = b;
    repeat (HALF) @(posedge CLK);
    #1;
    RCLK = 1'b1;
    repeat (HALF) @(posedge CLK);
    #1;
  endtask

  task automatic send_bits(input logic [8:0] d, input int n);
    for (int i = 0; i < n; i++) send_bit(d[i]);
  endtask

  function automatic logic [8:0] frame_word(input logic [7:0] d, input logic perr);
    return {(^d) ^ perr, d};
  endfunction

  task automatic send_frame(input logic [7:0] d, input logic perr);
    logic [8:0] w;
    w = frame_word(d, perr);
`ifdef SERIAL_PARITY_EN
    exp_q.push_back(perr ? 9'h100 : {1'b0, d});
`else
    exp_q.push_back({1'b0, d});
`endif
    send_bits(w, NBITS);
    repeat (4) @(posedge CLK);
    #1;
  endtask

  task automatic do_ack(input string name);
    ACK = 1'b1;
    @(posedge CLK);
    #1;
    ACK = 1'b0;
    checks++;
    if ({NEW_DATA, OVERRUN} !== 2'b00) begin
      errors++;
      $display("FAIL %s new_data/overrun=%b expected 00", name, {NEW_DATA, OVERRUN});
    end
  endtask

  // Scoreboard: every CHECK cycle resolves the oldest expected frame.
  always begin
    @(negedge CLK);
    if (DBG_STATE == ST_CHECK) begin
      mon_prev = {SIZE, COLOR};
      @(posedge CLK);
      #1;
      checks++;
      if (exp_q.size() == 0) begin
        errors++;
        $display("FAIL unexpected_frame size/color=%h", {SIZE, COLOR});
      end else begin
        mon_exp = exp_q.pop_front();
        if (mon_exp[8]) begin
          if (FRAME_ERR !== 1'b1 || {SIZE, COLOR} !== mon_prev) begin
            errors++;
            $display("FAIL rejected_frame frame_err=%b size/color=%h expected 1 and %h",
                     FRAME_ERR, {SIZE, COLOR}, mon_prev);
          end
        end else if ({SIZE, COLOR} !== mon_exp[7:0] || NEW_DATA !== 1'b1 || FRAME_ERR !== 1'b0) begin
          errors++;
          $display("FAIL committed_frame size/color=%h new_data=%b frame_err=%b expected %h 1 0",
                   {SIZE, COLOR}, NEW_DATA, FRAME_ERR, mon_exp[7:0]);
        end
      end
    end
  end

  task automatic test_reset();
    apply_reset();
    checks++;
    if ({SIZE, COLOR, NEW_DATA, OVERRUN, FRAME_ERR, ERR_COUNT, DBG_STATE} !==
        {4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, ST_IDLE}) begin
      errors++;
      $display("FAIL reset_values got %h %h %b %b %b %h %0d", SIZE, COLOR, NEW_DATA,
               OVERRUN, FRAME_ERR, ERR_COUNT, DBG_STATE);
    end
  endtask

  // Frame 8'h3A with explicit latency measured from the final RCLK rise.
  task automatic test_basic();
    logic [8:0] w;
    w = frame_word(8'h3A, 1'b0);
    exp_q.push_back({1'b0, 8'h3A});
    send_bits(w, NBITS - 1);
    RCLK  = 1'b0;
    RDATA = w[NBITS-1];
    repeat (HALF) @(posedge CLK);
    #1;
    RCLK = 1'b1;
    repeat (SS + 2) @(posedge CLK);
    #1;
    checks++;
    if (NEW_DATA !== 1'b0) begin
      errors++;
      $display("FAIL latency_early new_data=%b expected 0", NEW_DATA);
    end
    @(posedge CLK);
    #1;
    checks++;
    if ({NEW_DATA, SIZE, COLOR} !== {1'b1, 4'h3, 4'hA}) begin
      errors++;
      $display("FAIL latency_commit new_data=%b size/color=%h expected 1 3a", NEW_DATA, {SIZE, COLOR});
    end
    repeat (3) @(posedge CLK);
    #1;
    do_ack("basic_ack");
  endtask

  task automatic test_timeout();
    int pulses;
    apply_reset();
    send_bits(9'h015, 5);
    pulses = 0;
    for (int k = 0; k < IDLE_TO + 30; k++) begin
      @(posedge CLK);
      #1;
      if (FRAME_ERR === 1'b1) pulses++;
    end
    exp_err = exp_err + 1;
    checks++;
    if (pulses != 1 || ERR_COUNT !== 8'(exp_err)) begin
      errors++;
      $display("FAIL timeout_err pulses=%0d err_count=%0d expected 1 and %0d", pulses, ERR_COUNT, exp_err);
    end
    checks++;
    if ({SIZE, COLOR, NEW_DATA, DBG_STATE} !== {4'hF, 4'hF, 1'b0, ST_IDLE}) begin
      errors++;
      $display("FAIL timeout_discard size/color=%h new_data=%b state=%0d expected ff 0 0",
               {SIZE, COLOR}, NEW_DATA, DBG_STATE);
    end
    send_frame(8'h51, 1'b0);
    do_ack("timeout_next_ack");
  endtask

  task automatic test_overrun();
    bit found;
    send_frame(8'h12, 1'b0);
    checks++;
    if ({NEW_DATA, OVERRUN} !== 2'b10) begin
      errors++;
      $display("FAIL first_no_ack new_data/overrun=%b expected 10", {NEW_DATA, OVERRUN});
    end
    found = 1'b0;
    fork
      send_frame(8'h34, 1'b0);
      begin
        for (int k = 0; k < 200; k++) begin
          @(negedge CLK);
          if (DBG_STATE == ST_CHECK) begin
            found = 1'b1;
            break;
          end
        end
        if (found) begin
          ACK = 1'b1;
          @(posedge CLK);
          #1;
          ACK = 1'b0;
        end
      end
    join
    checks++;
    if (!found || {NEW_DATA, OVERRUN, SIZE, COLOR} !== {2'b11, 8'h34}) begin
      errors++;
      $display("FAIL overrun_commit_wins found=%b new/ovr=%b size/color=%h expected 1 11 34",
               found, {NEW_DATA, OVERRUN}, {SIZE, COLOR});
    end
    do_ack("overrun_ack");
    ACK = 1'b1;
    @(posedge CLK);
    #1;
    ACK = 1'b0;
    checks++;
    if ({NEW_DATA, OVERRUN, SIZE, COLOR} !== {2'b00, 8'h34}) begin
      errors++;
      $display("FAIL idle_ack new/ovr=%b size/color=%h expected 00 34", {NEW_DATA, OVERRUN}, {SIZE, COLOR});
    end
  endtask

`ifdef SERIAL_PARITY_EN
  task automatic test_parity();
    send_frame(8'h01, 1'b1);
    exp_err = exp_err + 1;
    checks++;
    if (ERR_COUNT !== 8'(exp_err) || NEW_DATA !== 1'b0) begin
      errors++;
      $display("FAIL parity_bad err_count=%0d new_data=%b expected %0d 0", ERR_COUNT, NEW_DATA, exp_err);
    end
    send_frame(8'h01, 1'b0);
    checks++;
    if ({NEW_DATA, SIZE, COLOR} !== {1'b1, 8'h01}) begin
      errors++;
      $display("FAIL parity_good new_data=%b size/color=%h expected 1 01", NEW_DATA, {SIZE, COLOR});
    end
    do_ack("parity_ack");
  endtask
`endif

  task automatic test_reset_midframe();
    send_frame(8'h12, 1'b0);
    send_bits(9'h00F, 4);
    RESET = 1'b1;
    repeat (2) @(posedge CLK);
    #1;
    checks++;
    if ({SIZE, COLOR, NEW_DATA, OVERRUN, FRAME_ERR, ERR_COUNT, DBG_STATE} !==
        {4'hF, 4'hF, 1'b0, 1'b0, 1'b0, 8'h00, ST_IDLE}) begin
      errors++;
      $display("FAIL midframe_reset got %h %h %b %b %b %h %0d", SIZE, COLOR, NEW_DATA,
               OVERRUN, FRAME_ERR, ERR_COUNT, DBG_STATE);
    end
    apply_reset();
    send_frame(8'hC7, 1'b0);
    checks++;
    if ({NEW_DATA, SIZE, COLOR} !== {1'b1, 4'hC, 4'h7}) begin
      errors++;
      $display("FAIL after_reset_frame new_data=%b size/color=%h expected 1 c7", NEW_DATA, {SIZE, COLOR});
    end
    do_ack("after_reset_ack");
  endtask

  task automatic test_saturate();
    bit seen;
    apply_reset();
    for (int i = 0; i < 260; i++) begin
      send_bits(9'h001, 1);
      seen = 1'b0;
      for (int k = 0; k < IDLE_TO + 30; k++) begin
        @(posedge CLK);
        #1;
        if (FRAME_ERR === 1'b1) begin
          seen = 1'b1;
          break;
        end
      end
      checks++;
      if (!seen) begin
        errors++;
        $display("FAIL saturate_pulse iteration=%0d got none expected 1", i);
      end
      if (i == 9 || i == 253 || i == 254) begin
        checks++;
        if (ERR_COUNT !== ((i == 9) ? 8'd10 : (i == 253) ? 8'hFE : 8'hFF)) begin
          errors++;
          $display("FAIL err_count_step iteration=%0d got %h", i, ERR_COUNT);
        end
      end
    end
    checks++;
    if (ERR_COUNT !== 8'hFF) begin
      errors++;
      $display("FAIL err_count_saturate got %h expected ff", ERR_COUNT);
    end
  endtask

  // Bound on total run time.
  initial begin
    #5_000_000;
    errors++;
    $display("FAIL watchdog run did not complete");
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Test sequence and final report.
  initial begin
    RESET = 1'b1;
    RCLK  = 1'b0;
    RDATA = 1'b0;
    ACK   = 1'b0;
    test_reset();
    test_basic();
    test_timeout();
`ifdef SERIAL_PARITY_EN
    test_parity();
`endif
    test_overrun();
    test_reset_midframe();
    test_saturate();
    repeat (10) @(posedge CLK);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain pending=%0d expected 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
